// File: rtl/tt_um_accelshark_psg_pkg.sv
// Shared widths and helpers for the PSG voice and mixer blocks.
package tt_um_accelshark_psg_pkg;

    localparam int VOICE_W = 5;
    localparam int ATTEN_W = 2;

    // Ceiling log2 usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

    // Width that holds the sum of `voices` signed voice contributions without overflow.
    function automatic int sum_width(input int voices);
        return VOICE_W + clog2(voices);
    endfunction

endpackage

// File: rtl/tt_um_accelshark_psg_mixer_if.sv
// Voice-side bus of the PSG stereo mixer: enable, packed voice contributions, attenuation, PDM outputs.
interface tt_um_accelshark_psg_mixer_if #(
    parameter int VOICES = 4
);

    logic                                               ena;
    logic [tt_um_accelshark_psg_pkg::VOICE_W*VOICES-1:0] mix_l;
    logic [tt_um_accelshark_psg_pkg::VOICE_W*VOICES-1:0] mix_r;
    logic [tt_um_accelshark_psg_pkg::ATTEN_W-1:0]        atten;
    logic                                               pdm_l;
    logic                                               pdm_r;
    logic                                               sample_tick;

    modport master (
        output ena, mix_l, mix_r, atten,
        input  pdm_l, pdm_r, sample_tick
    );

    modport slave (
        input  ena, mix_l, mix_r, atten,
        output pdm_l, pdm_r, sample_tick
    );

endinterface

// File: rtl/tt_um_accelshark_psg_sdm.sv
// First-order sigma-delta modulator: the accumulator carry is the PDM bit, density = level / 2^W.
module tt_um_accelshark_psg_sdm #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ena,
    input  logic [W-1:0] level,
    output logic         pdm
);

    logic [W-1:0] acc;
    logic [W:0]   total;

    assign total = {1'b0, acc} + {1'b0, level};

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            pdm <= 1'b0;
        end else if (ena) begin
            acc <= total[W-1:0];
            pdm <= total[W];
        end
    end

endmodule

// File: rtl/tt_um_accelshark_psg_mixer.sv
// PSG stereo output stage: sample capture, per-channel voice sum, master attenuation, PDM output.
module tt_um_accelshark_psg_mixer
    import tt_um_accelshark_psg_pkg::*;
#(
    parameter int VOICES     = 4,
    parameter int SAMPLE_DIV = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    tt_um_accelshark_psg_mixer_if.slave   bus
);

    localparam int SUM_W = sum_width(VOICES);
    localparam int CNT_W = clog2(SAMPLE_DIV);
    localparam int MIX_W = VOICE_W * VOICES;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [SUM_W-1:0] MID      = {1'b1, {(SUM_W-1){1'b0}}};

    logic [CNT_W-1:0]       cnt;
    logic                   tick_q;
    logic                   sum_pend;
    logic [MIX_W-1:0]       cap_l;
    logic [MIX_W-1:0]       cap_r;
    logic [ATTEN_W-1:0]     cap_atten;
    logic signed [SUM_W-1:0] sum_l;
    logic signed [SUM_W-1:0] sum_r;
    logic signed [SUM_W-1:0] sum_next_l;
    logic signed [SUM_W-1:0] sum_next_r;
    logic signed [SUM_W-1:0] shift_l;
    logic signed [SUM_W-1:0] shift_r;
    logic [SUM_W-1:0]       level_l;
    logic [SUM_W-1:0]       level_r;
    logic [SUM_W-1:0]       level_next_l;
    logic [SUM_W-1:0]       level_next_r;

    // Sample counter and capture registers; captured values stay stable for a full sample period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            tick_q    <= 1'b0;
            // NOTE: capture registers are plain flops, so they are reset to give a known silent first sample.
            cap_l     <= '0;
            cap_r     <= '0;
            cap_atten <= '0;
        end else if (bus.ena) begin
            if (cnt == CNT_LAST) begin
                cnt       <= '0;
                tick_q    <= 1'b1;
                cap_l     <= bus.mix_l;
                cap_r     <= bus.mix_r;
                cap_atten <= bus.atten;
            end else begin
                cnt    <= cnt + CNT_W'(1);
                tick_q <= 1'b0;
            end
        end
    end

    // The tick flop holds while disabled so a pending sum is never lost; only the visible pulse is gated.
    assign bus.sample_tick = tick_q & bus.ena;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sum_next_l = '0;
        sum_next_r = '0;
        for (int i = 0; i < VOICES; i++) begin
            sum_next_l = sum_next_l + {{(SUM_W-VOICE_W){cap_l[i*VOICE_W + VOICE_W-1]}},
                                       cap_l[i*VOICE_W +: VOICE_W]};
            sum_next_r = sum_next_r + {{(SUM_W-VOICE_W){cap_r[i*VOICE_W + VOICE_W-1]}},
                                       cap_r[i*VOICE_W +: VOICE_W]};
        end
    end

    // Attenuate, then offset the signed result to an unsigned level centred on MID.
    assign shift_l      = sum_l >>> cap_atten;
    assign shift_r      = sum_r >>> cap_atten;
    assign level_next_l = $unsigned(shift_l) + MID;
    assign level_next_r = $unsigned(shift_r) + MID;

    // Two-stage pipeline: sum on the edge after capture, level on the edge after that.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_pend <= 1'b0;
            sum_l    <= '0;
            sum_r    <= '0;
            level_l  <= MID;
            level_r  <= MID;
        end else if (bus.ena) begin
            sum_pend <= tick_q;
            if (tick_q) begin
                sum_l <= sum_next_l;
                sum_r <= sum_next_r;
            end
            if (sum_pend) begin
                level_l <= level_next_l;
                level_r <= level_next_r;
            end
        end
    end

    tt_um_accelshark_psg_sdm #(
        .W (SUM_W)
    ) u_sdm_l (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (bus.ena),
        .level (level_l),
        .pdm   (bus.pdm_l)
    );

    tt_um_accelshark_psg_sdm #(
        .W (SUM_W)
    ) u_sdm_r (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (bus.ena),
        .level (level_r),
        .pdm   (bus.pdm_r)
    );

endmodule

// File: doc/tt_um_accelshark_psg_mixer.md
# tt_um_accelshark_psg_mixer

Stereo output stage of the PSG. Sits directly downstream of the voice instances and consumes their 5-bit signed `mix_l`/`mix_r` contributions. Each sample period it captures all voices and sums them per channel, then applies a master attenuation shift. The result drives two first-order sigma-delta modulators, giving one-bit PDM outputs that the board filters to analog.

## Interface
Parameters:
- `VOICES`, 4: number of voice instances summed; must be a power of two, ≥2.
- `SAMPLE_DIV`, 16: `clk` cycles (counted only while `ena` is high) per input capture; ≥4.

Derived width:
- `SUM_W` = 5 + clog2(`VOICES`). This is 7 at the default.

Ports:
- `clk` input 1: system clock, same clock that feeds the voices' divider chain.
- `rst_n` input 1: reset. One clock; reset is asynchronous and active-low.
- `ena` input 1: design enable. Low freezes all state.
- `mix_l` input 5*`VOICES`: left contributions.
  - Voice i occupies `[5i+4:5i]`, two's complement, range −15..+15.
- `mix_r` input 5*`VOICES`: right contributions, same packing.
- `atten` input 2: master attenuation, arithmetic right shift by 0..3.
- `pdm_l` output 1: left PDM bit, registered.
- `pdm_r` output 1: right PDM bit, registered.
- `sample_tick` output 1: one-cycle pulse, high in the cycle after each capture edge.

## Operation
- Sample counter `cnt` runs 0..`SAMPLE_DIV`−1. It advances only when `ena`=1 and wraps to 0.
- Capture edge is the edge where `ena`=1 and `cnt`=`SAMPLE_DIV`−1. On that edge:
  - `mix_l`, `mix_r` and `atten` are registered into capture registers.
  - `sample_tick` is set to 1. On every other edge it is set to 0.
- Sum stage, on the edge where `sample_tick`=1 and `ena`=1:
  - Per channel, each captured voice is sign-extended to `SUM_W` bits.
  - All voices are summed into a `SUM_W`-bit signed register. No overflow is possible.
- Level stage, on the next edge with `ena`=1:
  - level = (sum >>> atten) + 2^(`SUM_W`−1), taken as `SUM_W`-bit unsigned.
  - At the default width the range is 4..124, and silence maps to 64.
  - The level holds until the next sample reaches this stage.
- Sigma-delta, on every `ena`=1 edge, per channel:
  - {carry, acc} = acc + level, with `acc` `SUM_W` bits.
  - `pdm` is set to carry.
  - Ones-density equals level / 2^`SUM_W`.
- `ena`=0: counter, capture, sum, level, accumulators and `pdm_*` all hold. `sample_tick` is forced to 0.

## Timing
- Reset values:
  - `cnt`=0, `acc`=0, `sample_tick`=0, `pdm_l`=`pdm_r`=0.
  - Capture registers and sums = 0.
  - Levels = 2^(`SUM_W`−1), which is 64 at the default.
- Silence after reset: `pdm` sequence is 0,1,0,1,…
- Latency, with `ena` held high and E0 = capture edge:
  - E1: sum updates.
  - E2: level updates.
  - E3: first `pdm` bit computed from the new level.
- First capture edge after reset is the `SAMPLE_DIV`-th `ena` edge.
- `sample_tick` period is exactly `SAMPLE_DIV` enabled cycles.
- Input or `atten` changes between capture edges are ignored. This includes changes in the capture cycle's successor.
- A `SAMPLE_DIV` as small as 4 still lets each pipeline stage complete before the next capture.
- Reset asserted mid-operation: all registers take their reset values immediately, without waiting for a clock edge. After release, the counter restarts from 0.
- Both channels share counter and ticks, so they update on identical edges.

## Structure
- Shared package `tt_um_accelshark_psg_pkg`:
  - `VOICE_W`=5.
  - clog2 helper.
  - `SUM_W` derivation.
- The voice and mixer reference the package rather than hard-coding widths.
- One sub-module `tt_um_accelshark_psg_sdm`:
  - Parameter `W`.
  - Ports `clk`, `rst_n`, `ena`, `level[W-1:0]`, `pdm`.
  - Holds `acc`.
  - Instantiated twice, once per channel.
- Counter, capture, sum and level pipeline live in the top mixer.

## Test plan
- Reset, then all inputs 0, `atten`=0. Expected: `pdm_l`/`pdm_r` exactly 0,1,0,1…, and 64 ones in any 128-cycle window.
- All left voices +15, all right voices −15, `atten`=0. Expected, after E3:
  - Level_l = 124, with 124 ±1 ones per 128 cycles on `pdm_l`.
  - Level_r = 4, with 4 ±1 ones on `pdm_r`.
- Same sums with `atten`=2. Expected:
  - Left: 60>>>2 = 15, level 79.
  - Right: −60>>>2 = −15, level 49.
  - Ones-density 79/128 and 49/128.
- Change `mix_l` from all 0 to all +15 one cycle after `sample_tick`. Expected:
  - Level unchanged for the rest of that sample period.
  - Level becomes 124 exactly 2 edges after the next capture edge.
- Drop `ena` for 50 cycles mid-period. Expected:
  - `pdm_*` and `acc` frozen, no `sample_tick`.
  - Tick-to-tick spacing measured in `clk` grows by exactly 50.
- Assert `rst_n` low asynchronously while level_l = 124. Expected:
  - `pdm_l` goes to 0 before the next clock edge.
  - Level returns to 64.
  - The first tick after release comes `SAMPLE_DIV` cycles later.
